// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared ALU opcodes, branch condition codes and flag types
package wisc_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_NAND = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b1100;
   localparam logic [3:0] ALU_SRL  = 4'b1110;
   localparam logic [3:0] ALU_SRA  = 4'b1111;

   localparam logic [2:0] COND_NE     = 3'b000;
   localparam logic [2:0] COND_EQ     = 3'b001;
   localparam logic [2:0] COND_GT     = 3'b010;
   localparam logic [2:0] COND_LT     = 3'b011;
   localparam logic [2:0] COND_GTE    = 3'b100;
   localparam logic [2:0] COND_LTE    = 3'b101;
   localparam logic [2:0] COND_OVFL   = 3'b110;
   localparam logic [2:0] COND_ALWAYS = 3'b111;

   typedef struct packed {
      logic z;
      logic n;
      logic v;
   } flags_t;

   typedef enum logic {
      ST_RUN,
      ST_SHADOW
   } fsm_t;

   typedef enum logic [1:0] {
      FUPD_NONE,
      FUPD_Z,
      FUPD_ZNV
   } fupd_t;

   // Which flags an opcode is allowed to write; everything else leaves them alone.
   function automatic fupd_t flag_update_kind(input logic [3:0] op);
      case (op)
         ALU_ADD, ALU_SUB:                             return FUPD_ZNV;
         ALU_NAND, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA: return FUPD_Z;
         default:                                      return FUPD_NONE;
      endcase
   endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational branch condition evaluation against a flag set
module cond_eval
   import wisc_pkg::*;
(
   input  flags_t     i_flags,
   input  logic [2:0] i_cond,
   output logic       o_take
);

   always_comb begin
      o_take = 1'b0;
      case (i_cond)
         COND_NE:     o_take = ~i_flags.z;
         COND_EQ:     o_take = i_flags.z;
         COND_GT:     o_take = ~i_flags.z & ~i_flags.n;
         COND_LT:     o_take = i_flags.n;
         COND_GTE:    o_take = i_flags.z | ~i_flags.n;
         COND_LTE:    o_take = i_flags.n | i_flags.z;
         COND_OVFL:   o_take = i_flags.v;
         COND_ALWAYS: o_take = 1'b1;
      endcase
   end

endmodule

// File: rtl/ex_flag_branch_unit.sv
// rtl/ex_flag_branch_unit.sv - EX-stage flag register, branch resolution and shadow squash
module ex_flag_branch_unit
   import wisc_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int SHADOW = 2
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [3:0]        ex_alu_ctrl,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              alu_z,
   input  logic              alu_n,
   input  logic              alu_v,
   input  logic              ex_is_branch,
   input  logic [2:0]        ex_cond,
   input  logic [DATA_W-1:0] ex_br_target,
   input  logic              stall,
   input  logic              flush,
   output logic              flag_z,
   output logic              flag_n,
   output logic              flag_v,
   output logic              br_taken,
   output logic [DATA_W-1:0] br_target,
   output logic              mem_valid,
   output logic [DATA_W-1:0] mem_result
);

   localparam logic [2:0] SHADOW_LD = 3'(SHADOW);

   fsm_t              r_state;
   fsm_t              w_state_nxt;
   logic [2:0]        r_shadow_cnt;
   logic [2:0]        w_shadow_cnt_nxt;
   flags_t            r_flags;
   flags_t            w_flags_nxt;
   logic              r_br_taken;
   logic [DATA_W-1:0] r_br_target;
   logic              r_mem_valid;
   logic [DATA_W-1:0] r_mem_result;

   logic              w_squash;
   logic              w_live;
   logic              w_cond_true;
   logic              w_taken;
   fupd_t             w_fupd;

   assign w_squash = (r_state == ST_SHADOW) | flush;
   assign w_live   = ex_valid & ~w_squash;
   assign w_fupd   = flag_update_kind(ex_alu_ctrl);

   // Conditions look at the registered flags only, never the same-cycle ALU outputs.
   cond_eval u_cond_eval (
      .i_flags (r_flags),
      .i_cond  (ex_cond),
      .o_take  (w_cond_true)
   );

   assign w_taken = w_live & ex_is_branch & w_cond_true & ~stall;

   always_comb begin
      w_flags_nxt = r_flags;
      if (w_live & ~stall & ~ex_is_branch) begin
         case (w_fupd)
            FUPD_ZNV: w_flags_nxt = '{z: alu_z, n: alu_n, v: alu_v};
            FUPD_Z:   w_flags_nxt.z = alu_z;
            default:  w_flags_nxt = r_flags;
         endcase
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_shadow_cnt_nxt = r_shadow_cnt;
      if (flush) begin
         w_state_nxt      = ST_RUN;
         w_shadow_cnt_nxt = 3'd0;
      end else if (!stall) begin
         case (r_state)
            ST_RUN: begin
               if (w_taken) begin
                  w_state_nxt      = ST_SHADOW;
                  w_shadow_cnt_nxt = SHADOW_LD;
               end
            end
            ST_SHADOW: begin
               if (r_shadow_cnt <= 3'd1) begin
                  w_state_nxt      = ST_RUN;
                  w_shadow_cnt_nxt = 3'd0;
               end else begin
                  w_shadow_cnt_nxt = r_shadow_cnt - 3'd1;
               end
            end
            default: begin
               w_state_nxt      = ST_RUN;
               w_shadow_cnt_nxt = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_RUN;
         r_shadow_cnt <= 3'd0;
         r_flags      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_shadow_cnt <= w_shadow_cnt_nxt;
         r_flags      <= w_flags_nxt;
      end
   end

   // w_taken already excludes stalls, so the redirect pulse can never stretch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_br_taken   <= 1'b0;
         r_br_target  <= '0;
         r_mem_valid  <= 1'b0;
         r_mem_result <= '0;
      end else begin
         r_br_taken <= w_taken;
         if (w_taken) begin
            r_br_target <= ex_br_target;
         end
         if (flush) begin
            r_mem_valid <= 1'b0;
         end else if (!stall) begin
            r_mem_valid <= w_live & ~ex_is_branch;
         end
         if (!stall) begin
            r_mem_result <= ex_result;
         end
      end
   end

   assign flag_z     = r_flags.z;
   assign flag_n     = r_flags.n;
   assign flag_v     = r_flags.v;
   assign br_taken   = r_br_taken;
   assign br_target  = r_br_target;
   assign mem_valid  = r_mem_valid;
   assign mem_result = r_mem_result;

endmodule

// File: tb/tb_ex_flag_branch_unit.sv
// tb/tb_ex_flag_branch_unit.sv - directed and random self-checking bench for ex_flag_branch_unit
module tb_ex_flag_branch_unit;

   localparam int DATA_W = 16;
   localparam int SHADOW = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ex_valid;
   logic [3:0]        ex_alu_ctrl;
   logic [DATA_W-1:0] ex_result;
   logic              alu_z, alu_n, alu_v;
   logic              ex_is_branch;
   logic [2:0]        ex_cond;
   logic [DATA_W-1:0] ex_br_target;
   logic              stall, flush;
   logic              flag_z, flag_n, flag_v;
   logic              br_taken;
   logic [DATA_W-1:0] br_target;
   logic              mem_valid;
   logic [DATA_W-1:0] mem_result;

   int n_asrt = 0;
   int n_fail = 0;

   bit              m_z, m_n, m_v, m_brt, m_mv;
   logic [DATA_W-1:0] m_tgt, m_res;
   int              m_left;

   always #5 clk = ~clk;

   ex_flag_branch_unit #(.DATA_W(DATA_W), .SHADOW(SHADOW)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl),
      .ex_result(ex_result), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
      .ex_is_branch(ex_is_branch), .ex_cond(ex_cond), .ex_br_target(ex_br_target),
      .stall(stall), .flush(flush), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
      .br_taken(br_taken), .br_target(br_target), .mem_valid(mem_valid),
      .mem_result(mem_result)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit cond_holds(input int c);
      case (c)
         0: return !m_z;
         1: return m_z;
         2: return !m_z && !m_n;
         3: return m_n;
         4: return m_z || !m_n;
         5: return m_n || m_z;
         6: return m_v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic m_reset();
      m_z = 0; m_n = 0; m_v = 0; m_brt = 0; m_mv = 0;
      m_tgt = '0; m_res = '0; m_left = 0;
   endtask

   task automatic model_edge();
      bit live, taken;
      int op;
      op    = int'(ex_alu_ctrl);
      live  = ex_valid && !(flush || m_left > 0);
      taken = live && ex_is_branch && cond_holds(int'(ex_cond)) && !stall;
      if (live && !stall && !ex_is_branch) begin
         if (op == 0 || op == 1) begin
            m_z = alu_z; m_n = alu_n; m_v = alu_v;
         end else if (op == 4 || op == 8 || op == 12 || op == 14 || op == 15) begin
            m_z = alu_z;
         end
      end
      m_brt = taken;
      if (taken) m_tgt = ex_br_target;
      if (flush) m_mv = 0;
      else if (!stall) m_mv = live && !ex_is_branch;
      if (!stall) m_res = ex_result;
      if (flush) m_left = 0;
      else if (!stall) begin
         if (m_left > 0) m_left = m_left - 1;
         else if (taken) m_left = SHADOW;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".flag_z"},     32'(flag_z),     32'(m_z));
      chk({tag, ".flag_n"},     32'(flag_n),     32'(m_n));
      chk({tag, ".flag_v"},     32'(flag_v),     32'(m_v));
      chk({tag, ".br_taken"},   32'(br_taken),   32'(m_brt));
      chk({tag, ".br_target"},  32'(br_target),  32'(m_tgt));
      chk({tag, ".mem_valid"},  32'(mem_valid),  32'(m_mv));
      chk({tag, ".mem_result"}, 32'(mem_result), 32'(m_res));
   endtask

   task automatic drive(input bit v, input logic [3:0] op, input logic [15:0] res,
                        input bit z, input bit n, input bit ov, input bit br,
                        input logic [2:0] c, input logic [15:0] t, input bit st, input bit fl);
      ex_valid = v; ex_alu_ctrl = op; ex_result = res;
      alu_z = z; alu_n = n; alu_v = ov;
      ex_is_branch = br; ex_cond = c; ex_br_target = t;
      stall = st; flush = fl;
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      drive(0, 4'h0, 16'h0, 0, 0, 0, 0, 3'd0, 16'h0, 0, 0);
      rst_n = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      // SUB 6-6 then BEQ; two shadow instructions are squashed
      drive(1, 4'b0001, 16'h0000, 1, 0, 0, 0, 3'd0, 16'h0, 0, 0); cyc("t2.sub");
      chk("t2.sub_z", 32'(flag_z), 32'd1);
      drive(1, 4'b0000, 16'h0000, 0, 0, 0, 1, 3'b001, 16'h0040, 0, 0); cyc("t2.beq");
      chk("t2.br_taken", 32'(br_taken), 32'd1);
      chk("t2.br_target", 32'(br_target), 32'h0040);
      drive(1, 4'b0000, 16'h1111, 0, 1, 1, 0, 3'd0, 16'h0, 0, 0); cyc("t2.sh1");
      chk("t2.sh1_mv", 32'(mem_valid), 32'd0);
      chk("t2.sh1_pulse", 32'(br_taken), 32'd0);
      drive(1, 4'b0000, 16'h2222, 0, 1, 1, 0, 3'd0, 16'h0, 0, 0); cyc("t2.sh2");
      chk("t2.sh2_mv", 32'(mem_valid), 32'd0);
      chk("t2.sh2_flags", {29'd0, flag_z, flag_n, flag_v}, 32'b100);
      drive(1, 4'b0000, 16'h3333, 0, 0, 0, 0, 3'd0, 16'h0, 0, 0); cyc("t2.post");
      chk("t2.post_mv", 32'(mem_valid), 32'd1);

      // ADD sets N,V; XOR sets only Z; BOVFL taken, BGT not taken
      drive(1, 4'b0000, 16'h8000, 0, 1, 1, 0, 3'd0, 16'h0, 0, 0); cyc("t3.add");
      drive(1, 4'b1000, 16'h0000, 1, 0, 0, 0, 3'd0, 16'h0, 0, 0); cyc("t3.xor");
      chk("t3.flags", {29'd0, flag_z, flag_n, flag_v}, 32'b111);
      drive(1, 4'b0000, 16'h0, 0, 0, 0, 1, 3'b110, 16'h0ABC, 0, 0); cyc("t3.bovfl");
      chk("t3.bovfl_taken", 32'(br_taken), 32'd1);
      drive(0, 4'b0000, 16'h0, 0, 0, 0, 0, 3'd0, 16'h0, 0, 0); cyc("t3.idle1");
      cyc("t3.idle2");
      drive(1, 4'b0000, 16'h0, 0, 0, 0, 1, 3'b010, 16'h0DEF, 0, 0); cyc("t3.bgt");
      chk("t3.bgt_taken", 32'(br_taken), 32'd0);

      // Taken BNE held by stall for 3 cycles
      drive(1, 4'b0000, 16'h0005, 0, 0, 0, 0, 3'd0, 16'h0, 0, 0); cyc("t4.add");
      for (int i = 0; i < 3; i++) begin
         drive(1, 4'b0000, 16'h0, 0, 0, 0, 1, 3'b000, 16'h0100, 1, 0); cyc("t4.stall");
         chk("t4.stall_pulse", 32'(br_taken), 32'd0);
      end
      drive(1, 4'b0000, 16'h0, 0, 0, 0, 1, 3'b000, 16'h0100, 0, 0); cyc("t4.release");
      chk("t4.release_pulse", 32'(br_taken), 32'd1);
      drive(1, 4'b0000, 16'h0, 1, 0, 0, 0, 3'd0, 16'h0, 1, 0); cyc("t4.stall_after");
      chk("t4.pulse_drop", 32'(br_taken), 32'd0);
      drive(1, 4'b0000, 16'h0007, 1, 0, 0, 0, 3'd0, 16'h0, 0, 0); cyc("t4.sh1");
      chk("t4.sh1_mv", 32'(mem_valid), 32'd0);
      cyc("t4.sh2");
      chk("t4.sh2_mv", 32'(mem_valid), 32'd0);
      cyc("t4.post");
      chk("t4.post_mv", 32'(mem_valid), 32'd1);
      chk("t4.post_z", 32'(flag_z), 32'd1);

      // Flush in first shadow cycle releases the squash
      drive(1, 4'b0000, 16'h0001, 0, 0, 0, 0, 3'd0, 16'h0, 0, 0); cyc("t5.add0");
      drive(1, 4'b0000, 16'h0, 0, 0, 0, 1, 3'b111, 16'h1234, 0, 0); cyc("t5.br");
      drive(1, 4'b0000, 16'h0, 1, 0, 0, 0, 3'd0, 16'h0, 0, 1); cyc("t5.flush");
      chk("t5.flush_z", 32'(flag_z), 32'd0);
      chk("t5.flush_mv", 32'(mem_valid), 32'd0);
      drive(1, 4'b0000, 16'h0, 1, 0, 0, 0, 3'd0, 16'h0, 0, 0); cyc("t5.add1");
      chk("t5.add1_z", 32'(flag_z), 32'd1);
      chk("t5.add1_mv", 32'(mem_valid), 32'd1);

      // Unused opcode leaves flags alone but still goes to MEM
      drive(1, 4'b0000, 16'h0002, 0, 0, 0, 0, 3'd0, 16'h0, 0, 0); cyc("t6.add");
      drive(1, 4'b0010, 16'hBEEF, 1, 1, 1, 0, 3'd0, 16'h0, 0, 0); cyc("t6.op2");
      chk("t6.flags", {29'd0, flag_z, flag_n, flag_v}, 32'b000);
      chk("t6.mv", 32'(mem_valid), 32'd1);
      chk("t6.res", 32'(mem_result), 32'hBEEF);

      // Asynchronous reset in the middle of a shadow
      drive(1, 4'b0000, 16'h0, 0, 0, 0, 1, 3'b111, 16'h5555, 0, 0); cyc("t1.br");
      #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      check_all("t1.async");
      rst_n = 1'b1;
      drive(1, 4'b0000, 16'h0042, 1, 0, 0, 0, 3'd0, 16'h0, 0, 0); cyc("t1.after");
      chk("t1.after_mv", 32'(mem_valid), 32'd1);
      chk("t1.after_z", 32'(flag_z), 32'd1);

      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 4) != 0, 4'($urandom), 16'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom % 3) == 0, 3'($urandom), 16'($urandom),
               ($urandom % 5) == 0, ($urandom % 16) == 0);
         cyc("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
